pipelined_adder: RTL and testbench

Parametrised, pipelined N-bit adder/subtractor. It is the sequential successor to the combinational n_bit_adder. The carry chain is split into W-bit chunks, and each chunk is registered, so one operation is accepted per cycle at a fixed latency of N/W cycles. A valid flag, a global stall enable, a subtract mode and a signed-overflow flag are added. It sits in datapaths where a full-width ripple carry does not meet timing.

---
 rtl/pipelined_adder.sv | 138 +++++++++++++
 tb/tb_pipelined_adder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipelined_adder: N-bit add/sub, carry chain split into W-bit registered    |
// | stages, one op per enabled cycle, latency N/W.            Revision: 1.0    |
// +----------------------------------------------------------------------------+
module pipelined_adder #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         in_valid_i,
  input  logic         sub_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic         out_valid_o,
  output logic [N-1:0] sum_o,
  output logic         cout_o,
  output logic         ovf_o
);

  localparam int S = N / W;

  logic [N-1:0] bx;
  logic         c0;
  logic [S-1:0] carry;
  logic [S-1:0] valid_q;
  logic [N-1:0] sum_out;
  logic         ovf_q;

  // Subtract is folded into the operands before chunk 0 is captured.
  assign bx = sub_i ? ~b_i : b_i;
  assign c0 = sub_i | cin_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (en_i) begin
      valid_q <= (valid_q << 1) | S'(in_valid_i);
    end
  end

  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int D = S - 1 - k;

    logic [W-1:0] a_stg;
    logic [W-1:0] b_stg;
    logic         c_stg;
    logic [W:0]   add_d;
    logic [W-1:0] psum_q;
    logic         carry_q;

    if (k == 0) begin : g_head
      assign a_stg = a_i[W-1:0];
      assign b_stg = bx[W-1:0];
      assign c_stg = c0;
    end else begin : g_skew
      logic [W-1:0] a_dly_q [k];
      logic [W-1:0] b_dly_q [k];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < k; j++) begin
            a_dly_q[j] <= '0;
            b_dly_q[j] <= '0;
          end
        end else if (en_i) begin
          a_dly_q[0] <= a_i[k*W +: W];
          b_dly_q[0] <= bx[k*W +: W];
          for (int j = 1; j < k; j++) begin
            a_dly_q[j] <= a_dly_q[j-1];
            b_dly_q[j] <= b_dly_q[j-1];
          end
        end
      end

      assign a_stg = a_dly_q[k-1];
      assign b_stg = b_dly_q[k-1];
      assign c_stg = carry[k-1];
    end

    assign add_d = {1'b0, a_stg} + {1'b0, b_stg} + {{W{1'b0}}, c_stg};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        psum_q  <= '0;
        carry_q <= 1'b0;
      end else if (en_i) begin
        psum_q  <= add_d[W-1:0];
        carry_q <= add_d[W];
      end
    end

    assign carry[k] = carry_q;

    // Earlier chunks wait here so every chunk of one op leaves together.
    if (D == 0) begin : g_nodeskew
      assign sum_out[k*W +: W] = psum_q;
    end else begin : g_deskew
      logic [W-1:0] dsk_q [D];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < D; j++) begin
            dsk_q[j] <= '0;
          end
        end else if (en_i) begin
          dsk_q[0] <= psum_q;
          for (int j = 1; j < D; j++) begin
            dsk_q[j] <= dsk_q[j-1];
          end
        end
      end

      assign sum_out[k*W +: W] = dsk_q[D-1];
    end

    if (k == S - 1) begin : g_ovf
      // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (en_i) begin
          ovf_q <= (a_stg[W-1] ^ b_stg[W-1] ^ add_d[W-1]) ^ add_d[W];
        end
      end
    end
  end

  assign out_valid_o = valid_q[S-1];
  assign sum_o       = sum_out;
  assign cout_o      = carry[S-1];
  assign ovf_o       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// Testbench for pipelined_adder: directed and random ops against an arithmetic model.
module tb_pipelined_adder;

  localparam int N = 16;
  localparam int W = 4;
  localparam int S = N / W;

  typedef struct {
    logic        v;
    logic [15:0] s;
    logic        c;
    logic        o;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int   n_pass = 0;
  int   n_total = 0;
  res_t q[$];

  pipelined_adder #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en),
    .in_valid_i (in_valid),
    .sub_i      (sub),
    .a_i        (a),
    .b_i        (b),
    .cin_i      (cin),
    .out_valid_o(out_valid),
    .sum_o      (sum),
    .cout_o     (cout),
    .ovf_o      (ovf)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic v, input logic sb, input logic [15:0] aa,
                                 input logic [15:0] bb, input logic ci);
    res_t e;
    int ua, ub, sa, sbb, r, sr;
    ua  = int'(aa);
    ub  = int'(bb);
    sa  = int'($signed(aa));
    sbb = int'($signed(bb));
    if (sb) begin
      r   = ua - ub;
      e.c = (ua >= ub);
      sr  = sa - sbb;
    end else begin
      r   = ua + ub + int'(ci);
      e.c = (r > 65535);
      sr  = sa + sbb + int'(ci);
    end
    e.v = v;
    e.s = r[15:0];
    e.o = (sr > 32767) || (sr < -32768);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_total++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    res_t e;
    if (q.size() == S) begin
      e = q[0];
    end else begin
      e.v = 1'b0; e.s = '0; e.c = 1'b0; e.o = 1'b0;
    end
    chk("out_valid", 16'(out_valid), 16'(e.v));
    if (e.v) begin
      chk("sum", sum, e.s);
      chk("cout", 16'(cout), 16'(e.c));
      chk("ovf", 16'(ovf), 16'(e.o));
    end
  endtask

  task automatic step(input logic e, input logic v, input logic sb, input logic [15:0] aa,
                      input logic [15:0] bb, input logic ci);
    en = e; in_valid = v; sub = sb; a = aa; b = bb; cin = ci;
    @(posedge clk);
    if (rst_n && e) begin
      q.push_back(model(v, sb, aa, bb, ci));
      if (q.size() > S) void'(q.pop_front());
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'hFFFF;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    chk("rst_valid", 16'(out_valid), 16'h0);
    chk("rst_sum", sum, 16'h0);
    chk("rst_cout", 16'(cout), 16'h0);
    chk("rst_ovf", 16'(ovf), 16'h0);
    rst_n = 1'b1;
    idle(2);

    // Single op, valid for exactly one cycle
    step(1, 1, 0, 16'h0002, 16'h0000, 0);
    idle(5);

    // Full carry ripple, cin = 0 then cin = 1
    step(1, 1, 0, 16'hFFFF, 16'hFFFF, 0);
    step(1, 1, 0, 16'hFFFF, 16'hFFFF, 1);
    idle(4);

    // Back-to-back stream
    step(1, 1, 0, 16'h0FFF, 16'h0001, 0);
    step(1, 1, 0, 16'h00FF, 16'h0001, 0);
    step(1, 1, 0, 16'h7FFF, 16'h0001, 0);
    step(1, 1, 0, 16'h0000, 16'h0000, 0);
    idle(4);

    // Subtract, cin ignored
    step(1, 1, 1, 16'h0005, 16'h0007, 0);
    step(1, 1, 1, 16'h8000, 16'h0001, 1);
    idle(4);

    // Stall mid-flight, with junk operands presented during the stall
    step(1, 1, 0, 16'h1234, 16'h4321, 0);
    step(1, 1, 1, 16'h0001, 16'h0002, 0);
    step(0, 1, 0, 16'hAAAA, 16'h5555, 1);
    step(0, 1, 1, 16'hFFFF, 16'h0001, 0);
    step(1, 1, 0, 16'h7000, 16'h1000, 1);
    step(1, 1, 0, 16'hFFFF, 16'h0001, 0);
    idle(5);

    // Async reset with ops in flight
    step(1, 1, 0, 16'h1111, 16'h2222, 0);
    step(1, 1, 0, 16'h3333, 16'h4444, 1);
    step(1, 1, 1, 16'h0000, 16'h0001, 0);
    step(1, 1, 0, 16'hFFFF, 16'hFFFF, 1);
    step(1, 1, 1, 16'h8000, 16'h7FFF, 0);
    step(1, 1, 0, 16'h7FFF, 16'h7FFF, 0);
    #3;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("arst_valid", 16'(out_valid), 16'h0);
    chk("arst_sum", sum, 16'h0);
    chk("arst_cout", 16'(cout), 16'h0);
    chk("arst_ovf", 16'(ovf), 16'h0);
    idle(2);
    #3;
    rst_n = 1'b1;
    idle(10);

    // Random ops with random stalls
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), pick(), pick(), 1'($urandom));
    end
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
